combining_branch_predictor: RTL and testbench

//  Tournament predictor: responder side of the branch prediction path. Drives

---
 rtl/combining_branch_predictor_if.sv | 39 +++
 rtl/combining_branch_predictor.sv | 162 ++++++++++++++++
 tb/tb_combining_branch_predictor.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/combining_branch_predictor_if.sv
// Decode-lookup and EX-resolve signal bundle for the tournament predictor.
// master: hazard/decode/EX side; slave: the predictor itself.
interface combining_branch_predictor_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] i_pc;
    logic                  i_dec_valid;
    logic                  i_dec_is_jump;
    logic                  i_dec_advance;
    logic                  o_prediction;
    logic                  o_prediction1;
    logic                  o_prediction2;
    logic                  i_res_valid;
    logic                  i_res_outcome;
    logic                  i_res_prediction;
    logic                  i_res_prediction1;
    logic                  i_res_prediction2;
    logic                  o_fifo_full;
    logic [CW-1:0]         o_fifo_count;

    modport master (
        output i_pc, i_dec_valid, i_dec_is_jump, i_dec_advance,
        output i_res_valid, i_res_outcome, i_res_prediction,
        output i_res_prediction1, i_res_prediction2,
        input  o_prediction, o_prediction1, o_prediction2,
        input  o_fifo_full, o_fifo_count
    );

    modport slave (
        input  i_pc, i_dec_valid, i_dec_is_jump, i_dec_advance,
        input  i_res_valid, i_res_outcome, i_res_prediction,
        input  i_res_prediction1, i_res_prediction2,
        output o_prediction, o_prediction1, o_prediction2,
        output o_fifo_full, o_fifo_count
    );
endinterface

// File: rtl/combining_branch_predictor.sv
// Tournament predictor: bimodal + gshare + chooser, trained via an in-flight index FIFO.
// Optional BRANCH_PRED_STATS_EN adds resolve / mispredict counters.
module combining_branch_predictor #(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 8,
    parameter int GHR_BITS   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    combining_branch_predictor_if.slave bp
`ifdef BRANCH_PRED_STATS_EN
    ,
    output logic [31:0] o_stat_branches,
    output logic [31:0] o_stat_mispredicts
`endif
);
    localparam int   ENTRIES   = 1 << INDEX_BITS;
    localparam int   PW        = $clog2(FIFO_DEPTH);
    localparam int   CW        = PW + 1;
    localparam logic TAKEN     = 1'b1;
    localparam logic NOT_TAKEN = 1'b0;

    typedef logic [INDEX_BITS-1:0] idx_t;

    typedef struct packed {
        idx_t bidx;
        idx_t gidx;
    } inflight_t;

    logic [1:0]          bimodal [ENTRIES];
    logic [1:0]          gshare  [ENTRIES];
    logic [1:0]          chooser [ENTRIES];
    logic [GHR_BITS-1:0] ghr;
    inflight_t           fifo    [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;

    idx_t      bidx;
    idx_t      gidx;
    inflight_t head;
    logic      full;
    logic      push;
    logic      pop;
    logic      mispredict;
    logic      chooser_train;
    logic      chooser_up;
    logic      pred;
    logic      pred1;
    logic      pred2;
    logic      pc_unused;

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
        if (up) begin
            return (c == 2'b11) ? c : c + 2'd1;
        end
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    assign bidx = bp.i_pc[INDEX_BITS+1:2];
    assign gidx = bidx ^ idx_t'(ghr);
    assign pc_unused = ^{bp.i_pc[ADDR_WIDTH-1:INDEX_BITS+2], bp.i_pc[1:0]};

    // Lookup reads pre-update state; jumps and bubbles force fixed answers.
    always_comb begin
        pred1 = bimodal[bidx][1];
        pred2 = gshare[gidx][1];
        pred  = chooser[bidx][1] ? pred2 : pred1;
        if (!bp.i_dec_valid) begin
            pred1 = NOT_TAKEN;
            pred2 = NOT_TAKEN;
            pred  = NOT_TAKEN;
        end else if (bp.i_dec_is_jump) begin
            pred1 = TAKEN;
            pred2 = TAKEN;
            pred  = TAKEN;
        end
    end

    assign bp.o_prediction  = pred;
    assign bp.o_prediction1 = pred1;
    assign bp.o_prediction2 = pred2;

    assign full = (count == CW'(FIFO_DEPTH));
    assign push = bp.i_dec_valid & ~bp.i_dec_is_jump
                & bp.i_dec_advance & ~full;
    assign pop  = bp.i_res_valid & (count != '0);
    assign head = fifo[rd_ptr];

    assign mispredict    = pop & (bp.i_res_prediction != bp.i_res_outcome);
    assign chooser_train = pop & (bp.i_res_prediction1 != bp.i_res_prediction2);
    assign chooser_up    = (bp.i_res_prediction2 == bp.i_res_outcome);

    assign bp.o_fifo_full  = full;
    assign bp.o_fifo_count = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bimodal[i] <= 2'b01;
                gshare[i]  <= 2'b01;
                chooser[i] <= 2'b01;
            end
        end else if (pop) begin
            bimodal[head.bidx] <= sat_step(bimodal[head.bidx], bp.i_res_outcome);
            gshare[head.gidx]  <= sat_step(gshare[head.gidx], bp.i_res_outcome);
            if (chooser_train) begin
                chooser[head.bidx] <= sat_step(chooser[head.bidx], chooser_up);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (pop) begin
            ghr <= {ghr[GHR_BITS-2:0], bp.i_res_outcome == TAKEN};
        end
    end

    // A mispredict squashes every younger branch, including one pushed now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo[i] <= '0;
            end
        end else if (mispredict) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= '{bidx: bidx, gidx: gidx};
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef BRANCH_PRED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_stat_branches    <= '0;
            o_stat_mispredicts <= '0;
        end else begin
            if (pop) begin
                o_stat_branches <= o_stat_branches + 32'd1;
            end
            if (mispredict) begin
                o_stat_mispredicts <= o_stat_mispredicts + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_combining_branch_predictor.sv
// Directed bench for combining_branch_predictor (default parameters).
// Stats scenario compiles in only with BRANCH_PRED_STATS_EN.
module tb_combining_branch_predictor;
    localparam logic [31:0] PC_A = 32'h0040_0010;
    localparam logic [31:0] PC_B = 32'h0000_0100;
    localparam logic [31:0] PC_C = 32'h0000_0200;

    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    combining_branch_predictor_if #(.ADDR_WIDTH(32), .FIFO_DEPTH(4)) bp ();

`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] stat_br;
    logic [31:0] stat_mp;
`endif

    combining_branch_predictor #(
        .ADDR_WIDTH(32),
        .INDEX_BITS(8),
        .GHR_BITS(8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bp(bp)
`ifdef BRANCH_PRED_STATS_EN
        ,
        .o_stat_branches(stat_br),
        .o_stat_mispredicts(stat_mp)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic [31:0] pc, input logic v, input logic j, input logic a);
        bp.i_pc          = pc;
        bp.i_dec_valid   = v;
        bp.i_dec_is_jump = j;
        bp.i_dec_advance = a;
    endtask

    task automatic res(input logic v, input logic o, input logic p,
                       input logic p1, input logic p2);
        bp.i_res_valid       = v;
        bp.i_res_outcome     = o;
        bp.i_res_prediction  = p;
        bp.i_res_prediction1 = p1;
        bp.i_res_prediction2 = p2;
    endtask

    task automatic idle();
        dec(32'h0, 1'b0, 1'b0, 1'b0);
        res(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #12;
        total++;
        if (bp.o_fifo_count !== 3'd0)
            $display("FAIL reset_count got %0d want 0", bp.o_fifo_count);
        else passed++;
        total++;
        if (bp.o_fifo_full !== 1'b0)
            $display("FAIL reset_full got %b want 0", bp.o_fifo_full);
        else passed++;
        rst_n = 1'b1;
        tick();
        dec(PC_A, 1'b1, 1'b0, 1'b0);
        #1;
        total++;
        if ({bp.o_prediction, bp.o_prediction1, bp.o_prediction2} !== 3'b000)
            $display("FAIL reset_lookup got %b want 000",
                     {bp.o_prediction, bp.o_prediction1, bp.o_prediction2});
        else passed++;
        dec(PC_A, 1'b1, 1'b1, 1'b0);
        #1;
        total++;
        if ({bp.o_prediction, bp.o_prediction1, bp.o_prediction2} !== 3'b111)
            $display("FAIL jump_lookup got %b want 111",
                     {bp.o_prediction, bp.o_prediction1, bp.o_prediction2});
        else passed++;
        dec(PC_A, 1'b0, 1'b0, 1'b0);
        #1;
        total++;
        if ({bp.o_prediction, bp.o_prediction1, bp.o_prediction2} !== 3'b000)
            $display("FAIL bubble_lookup got %b want 000",
                     {bp.o_prediction, bp.o_prediction1, bp.o_prediction2});
        else passed++;
        idle();
    endtask

    task automatic test_bimodal_train();
        for (int r = 0; r < 2; r++) begin
            dec(PC_A, 1'b1, 1'b0, 1'b1);
            tick();
            idle();
            total++;
            if (bp.o_fifo_count !== 3'd1)
                $display("FAIL bim_push%0d got %0d want 1", r, bp.o_fifo_count);
            else passed++;
            res(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
            idle();
        end
        // bimodal[4]=11, gshare[4]=gshare[5]=10, ghr=3 -> gidx 7 still 01
        dec(PC_A, 1'b1, 1'b0, 1'b0);
        #1;
        total++;
        if ({bp.o_prediction, bp.o_prediction1, bp.o_prediction2} !== 3'b110)
            $display("FAIL bim_lookup got %b want 110",
                     {bp.o_prediction, bp.o_prediction1, bp.o_prediction2});
        else passed++;
        idle();
    endtask

    task automatic test_chooser_train();
        for (int r = 0; r < 2; r++) begin
            dec(PC_A, 1'b1, 1'b0, 1'b1);
            tick();
            idle();
            res(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            tick();
            idle();
        end
        total++;
        if (bp.o_fifo_count !== 3'd0)
            $display("FAIL chooser_count got %0d want 0", bp.o_fifo_count);
        else passed++;
        // chooser[4]=11 selects gshare; ghr=0x0F -> gidx 0x0B untouched (01)
        dec(PC_A, 1'b1, 1'b0, 1'b0);
        #1;
        total++;
        if ({bp.o_prediction, bp.o_prediction1, bp.o_prediction2} !== 3'b010)
            $display("FAIL chooser_lookup got %b want 010",
                     {bp.o_prediction, bp.o_prediction1, bp.o_prediction2});
        else passed++;
        idle();
        res(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        total++;
        if (bp.o_fifo_count !== 3'd0)
            $display("FAIL empty_resolve got %0d want 0", bp.o_fifo_count);
        else passed++;
    endtask

    task automatic test_fifo_full();
        for (int i = 1; i <= 4; i++) begin
            dec(PC_B, 1'b1, 1'b0, 1'b1);
            tick();
            total++;
            if (bp.o_fifo_count !== 3'(i))
                $display("FAIL fill%0d got %0d want %0d", i, bp.o_fifo_count, i);
            else passed++;
        end
        total++;
        if (bp.o_fifo_full !== 1'b1)
            $display("FAIL full_flag got %b want 1", bp.o_fifo_full);
        else passed++;
        tick();
        total++;
        if (bp.o_fifo_count !== 3'd4)
            $display("FAIL push_when_full got %0d want 4", bp.o_fifo_count);
        else passed++;
        res(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        total++;
        if ({bp.o_fifo_full, bp.o_fifo_count} !== 4'b0_011)
            $display("FAIL full_push_pop got %b want 0011",
                     {bp.o_fifo_full, bp.o_fifo_count});
        else passed++;
        tick();
        total++;
        if (bp.o_fifo_count !== 3'd3)
            $display("FAIL push_pop got %0d want 3", bp.o_fifo_count);
        else passed++;
        dec(PC_B, 1'b0, 1'b0, 1'b0);
        res(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        total++;
        if (bp.o_fifo_count !== 3'd0)
            $display("FAIL flush_alone got %0d want 0", bp.o_fifo_count);
        else passed++;
        dec(PC_B, 1'b1, 1'b0, 1'b0);
        tick();
        dec(PC_B, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        total++;
        if (bp.o_fifo_count !== 3'd0)
            $display("FAIL stall_or_jump_push got %0d want 0", bp.o_fifo_count);
        else passed++;
    endtask

    task automatic test_mispredict_flush();
        dec(PC_C, 1'b1, 1'b0, 1'b1);
        repeat (3) tick();
        total++;
        if (bp.o_fifo_count !== 3'd3)
            $display("FAIL three_inflight got %0d want 3", bp.o_fifo_count);
        else passed++;
        res(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        total++;
        if (bp.o_fifo_count !== 3'd0)
            $display("FAIL flush_with_push got %0d want 0", bp.o_fifo_count);
        else passed++;
        res(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        total++;
        if (bp.o_fifo_count !== 3'd0)
            $display("FAIL pushed_absent got %0d want 0", bp.o_fifo_count);
        else passed++;
        dec(PC_C, 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        total++;
        if (bp.o_fifo_count !== 3'd1)
            $display("FAIL refill got %0d want 1", bp.o_fifo_count);
        else passed++;
        res(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
    endtask

    task automatic test_async_reset();
        dec(PC_A, 1'b1, 1'b0, 1'b1);
        #1;
        total++;
        if (bp.o_prediction1 !== 1'b1)
            $display("FAIL trained_pred1 got %b want 1", bp.o_prediction1);
        else passed++;
        repeat (2) tick();
        idle();
        total++;
        if (bp.o_fifo_count !== 3'd2)
            $display("FAIL two_inflight got %0d want 2", bp.o_fifo_count);
        else passed++;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bp.o_fifo_full, bp.o_fifo_count} !== 4'b0_000)
            $display("FAIL async_reset got %b want 0000",
                     {bp.o_fifo_full, bp.o_fifo_count});
        else passed++;
        #2;
        rst_n = 1'b1;
        dec(PC_A, 1'b1, 1'b0, 1'b0);
        #1;
        total++;
        if ({bp.o_prediction, bp.o_prediction1, bp.o_prediction2} !== 3'b000)
            $display("FAIL reset_tables got %b want 000",
                     {bp.o_prediction, bp.o_prediction1, bp.o_prediction2});
        else passed++;
        // ghr must be 0: push at bidx 0 trains gshare[0], then ghr=1
        dec(32'h0, 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        res(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        dec(32'h4, 1'b1, 1'b0, 1'b0);
        #1;
        total++;
        if ({bp.o_prediction, bp.o_prediction1, bp.o_prediction2} !== 3'b001)
            $display("FAIL ghr_reset got %b want 001",
                     {bp.o_prediction, bp.o_prediction1, bp.o_prediction2});
        else passed++;
        dec(32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        total++;
        if ({bp.o_prediction, bp.o_prediction1, bp.o_prediction2} !== 3'b110)
            $display("FAIL ghr_shift got %b want 110",
                     {bp.o_prediction, bp.o_prediction1, bp.o_prediction2});
        else passed++;
        idle();
    endtask

`ifdef BRANCH_PRED_STATS_EN
    task automatic test_stats();
        logic [4:0] mis;
        mis = 5'b01010;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        total++;
        if ({stat_br, stat_mp} !== 64'd0)
            $display("FAIL stats_reset got %0d/%0d want 0/0", stat_br, stat_mp);
        else passed++;
        for (int r = 0; r < 5; r++) begin
            dec(PC_A, 1'b1, 1'b0, 1'b1);
            tick();
            idle();
            res(1'b1, 1'b1, ~mis[r], ~mis[r], ~mis[r]);
            tick();
            idle();
        end
        res(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        total++;
        if (stat_br !== 32'd5)
            $display("FAIL stat_branches got %0d want 5", stat_br);
        else passed++;
        total++;
        if (stat_mp !== 32'd2)
            $display("FAIL stat_mispredicts got %0d want 2", stat_mp);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_bimodal_train();
        test_chooser_train();
        test_fifo_full();
        test_mispredict_flush();
        test_async_reset();
`ifdef BRANCH_PRED_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
